debounce_pulse_t: RTL and testbench

Upstream conditioning stage for the T flip-flop.
- Takes a raw, asynchronous, bouncy push-button level.
- Synchronises it, then debounces it with a counter-qualified state machine.
- Emits exactly one single-cycle `t` pulse per debounced press, which feeds the T flip-flop's `t` input directly.
- Also exports the debounced level for status use.

---
 rtl/debounce_pulse_pkg.sv | 15 +
 rtl/sync_nff.sv | 20 ++
 rtl/debounce_pulse_t.sv | 106 ++++++++++
 tb/tb_debounce_pulse_t.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pulse_pkg.sv
// Shared state encoding and default timing constants for the button debouncer.
package debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int REPEAT_CYCLES_DEF   = 8;

endpackage

// File: rtl/sync_nff.sv
// STAGES-deep flop synchroniser for an asynchronous level; synchronous active-high reset.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_pulse_t.sv
// Synchronise + debounce a push button and emit one t pulse per accepted press.
// Optional auto-repeat while held: define DEBOUNCE_PULSE_T_AUTO_REPEAT_EN.
module debounce_pulse_t
  import debounce_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic t,
  output logic btn_level,
  output logic busy
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("SYNC_STAGES must be 2 or 3");
    end
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
      $error("DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end
  endgenerate

  logic             s;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );

  // cnt doubles as the repeat counter while in PRESSED; it is zeroed on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      t         <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      t <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            t         <= 1'b1;
            btn_level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
          end
`ifdef DEBOUNCE_PULSE_T_AUTO_REPEAT_EN
          else if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
            cnt <= '0;
            t   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        WAIT_RELEASE: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == WAIT_PRESS) || (state == WAIT_RELEASE);

endmodule

// File: tb/tb_debounce_pulse_t.sv
// Self-checking bench for debounce_pulse_t: a vector table, directed corner cases and random bounce.
module tb_debounce_pulse_t;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic reset, btn_in;
  logic t, btn_level, busy;

  always #5 clk = ~clk;

  debounce_pulse_t #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .t(t), .btn_level(btn_level), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulses = 0;
  int last_pulse = 0;

  // Reference: level flips once the last DEB+1 samples seen by the FSM all disagree with it.
  logic [SYNC-1:0] m_dly;
  logic m_level, m_t, m_busy;
  int run1, run0, anchor;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic b);
    logic s_seen;
    m_t = 1'b0;
    if (r) begin
      m_dly = '0; m_level = 1'b0; m_busy = 1'b0;
      run1 = 0; run0 = 0; anchor = 0;
      return;
    end
    s_seen = m_dly[SYNC-1];
    m_dly  = {m_dly[SYNC-2:0], b};
    if (s_seen) begin run1++; run0 = 0; end
    else        begin run0++; run1 = 0; end
    if (!m_level && run1 == DEB + 1) begin
      m_level = 1'b1; m_t = 1'b1; anchor = DEB + 1;
    end else if (m_level && run0 == DEB + 1) begin
      m_level = 1'b0;
    end else if (m_level && s_seen && run1 == 1) begin
      anchor = 1;
    end
`ifdef DEBOUNCE_PULSE_T_AUTO_REPEAT_EN
    else if (m_level && s_seen && run1 > anchor && (run1 - anchor) % REP == 0) begin
      m_t = 1'b1;
    end
`endif
    m_busy = (!m_level && run1 >= 1) || (m_level && run0 >= 1);
  endtask

  task automatic step(input logic r, input logic b);
    reset  = r;
    btn_in = b;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, b);
    if (t === 1'b1) begin pulses++; last_pulse = cyc; end
  endtask

  task automatic step_m(input logic r, input logic b);
    step(r, b);
    chk("t", int'(t), int'(m_t));
    chk("btn_level", int'(btn_level), int'(m_level));
    chk("busy", int'(busy), int'(m_busy));
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step_m(1'b0, b);
  endtask

  typedef struct {
    logic r, b;
    logic et, el, eb;
  } vec_t;

  vec_t tbl[18];

  task automatic set_vec(input int i, input logic r, input logic b,
                         input logic et, input logic el, input logic eb);
    tbl[i].r = r; tbl[i].b = b; tbl[i].et = et; tbl[i].el = el; tbl[i].eb = eb;
  endtask

  initial begin
    int p0, j, fall, start, nr, len;
    logic b;
    reset = 1'b1;
    btn_in = 1'b0;
    m_dly = '0; m_level = 0; m_t = 0; m_busy = 0; run1 = 0; run0 = 0; anchor = 0;

    // Clean press: reset on edges 1-2, btn first sampled high at edge 10 (table index = edge-1).
    for (int i = 0; i < 18; i++) set_vec(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 9; i < 18; i++) set_vec(i, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 11; i < 15; i++) tbl[i].eb = 1'b1;
    tbl[15].et = 1'b1;
    for (int i = 15; i < 18; i++) tbl[i].el = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].b);
      chk("tbl_t", int'(t), int'(tbl[i].et));
      chk("tbl_btn_level", int'(btn_level), int'(tbl[i].el));
      chk("tbl_busy", int'(busy), int'(tbl[i].eb));
    end
    chk("clean_single_pulse", pulses, 1);

    // Release bounce: hold, then 0,1,0, then low. Fall counts from the first low sample, like the press side.
    pulses = 0;
    hold(1'b1, 20);
    step_m(1'b0, 1'b0);
    step_m(1'b0, 1'b1);
    j = cyc;
    fall = 0;
    for (int i = 0; i < 12; i++) begin
      step_m(1'b0, 1'b0);
      if (fall == 0 && btn_level === 1'b0) fall = cyc;
    end
    chk("release_fall_edge", fall, j + 1 + SYNC + DEB);
    chk("release_no_pulse", pulses, 0);

    // Press bounce: 1,0,1,0 then held.
    pulses = 0;
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
    start = cyc + 1;
    hold(1'b1, 12);
    chk("bounce_one_pulse", pulses, 1);
    chk("bounce_pulse_edge", last_pulse, start + SYNC + DEB);
    hold(1'b0, 10);

    // Short glitch: 3 high cycles never reach the debounce threshold.
    pulses = 0;
    hold(1'b1, 3);
    hold(1'b0, 8);
    chk("glitch_no_pulse", pulses, 0);
    chk("glitch_level", int'(btn_level), 0);
    chk("glitch_idle", int'(busy), 0);

    // Reset in WAIT_PRESS with cnt=2 (btn high at k, reset at k+5), then a fresh press.
    hold(1'b1, 5);
    step_m(1'b1, 1'b1);
    chk("rst_wp_t", int'(t), 0);
    chk("rst_wp_level", int'(btn_level), 0);
    chk("rst_wp_busy", int'(busy), 0);
    hold(1'b0, 3);
    pulses = 0;
    start = cyc + 1;
    hold(1'b1, 8);
    chk("after_rst_pulse_edge", last_pulse, start + SYNC + DEB);
    chk("after_rst_one_pulse", pulses, 1);
    hold(1'b0, 10);

    // Reset on the edge the pulse would rise.
    pulses = 0;
    hold(1'b1, 6);
    step_m(1'b1, 1'b1);
    chk("rst_pulse_t", int'(t), 0);
    chk("rst_pulse_level", int'(btn_level), 0);
    chk("rst_pulse_none", pulses, 0);
    hold(1'b0, 3);
    start = cyc + 1;
    hold(1'b1, 7);
    chk("fresh_pulse_edge", last_pulse, start + SYNC + DEB);
    chk("fresh_one_pulse", pulses, 1);

    // Long hold: auto-repeat pulses at +8/+16/+24, else nothing more.
    p0 = last_pulse;
    pulses = 0;
    hold(1'b1, 30);
`ifdef DEBOUNCE_PULSE_T_AUTO_REPEAT_EN
    chk("repeat_count", pulses, 3);
    chk("repeat_last_edge", last_pulse, p0 + 3 * REP);
`else
    chk("hold_no_repeat", pulses, 0);
`endif
    hold(1'b0, 10);

    // Random bounce with occasional resets against the reference model.
    for (int i = 0; i < 150; i++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      nr  = $urandom_range(0, 40);
      for (int k = 0; k < len; k++) step_m(nr == 0 && k == 0, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
